// File: rtl/led_scan_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// led_scan_frame_decoder_if
//
// Purpose:
//   Bundles the scan-word input stream, the random-access read port and the
//   per-frame status outputs of led_scan_frame_decoder. The signal names match
//   the decoder's documented pin names.
//
// Signals:
//   SAMPLE      single-cycle strobe, LEDin valid in that cycle
//   LEDin[9:0]  scan word: [9:8] colour, [7] unused, [6:0] pixel index y*8+x
//   RD_ADDR     read pixel index
//   RD_DATA     colour at RD_ADDR in the display buffer (1-cycle latency)
//   FRAME_DONE  one-cycle pulse after a frame commit
//   BALL_VALID  committed frame contained a ball word
//   BALL_X/Y    position of the last ball word of the committed frame
//   CONFLICT    committed frame had a colour clash on one pixel
//   ERR_CNT     saturating count of reserved-colour words
//   STALE       no SAMPLE seen for TIMEOUT cycles
//
// Modports:
//   master  game core / checker side (drives SAMPLE, LEDin, RD_ADDR)
//   slave   decoder side
// ---------------------------------------------------------------------------
interface led_scan_frame_decoder_if;
    logic       SAMPLE;
    logic [9:0] LEDin;
    logic [6:0] RD_ADDR;
    logic [1:0] RD_DATA;
    logic       FRAME_DONE;
    logic       BALL_VALID;
    logic [2:0] BALL_X;
    logic [3:0] BALL_Y;
    logic       CONFLICT;
    logic [7:0] ERR_CNT;
    logic       STALE;

    modport master (
        output SAMPLE, LEDin, RD_ADDR,
        input  RD_DATA, FRAME_DONE, BALL_VALID, BALL_X, BALL_Y,
               CONFLICT, ERR_CNT, STALE
    );

    modport slave (
        input  SAMPLE, LEDin, RD_ADDR,
        output RD_DATA, FRAME_DONE, BALL_VALID, BALL_X, BALL_Y,
               CONFLICT, ERR_CNT, STALE
    );
endinterface

// File: rtl/led_scan_frame_decoder.sv
// ---------------------------------------------------------------------------
// led_scan_frame_decoder
//
// Purpose:
//   Receives the time-multiplexed 10-bit LED scan words (one pixel per slot)
//   and rebuilds an 8x16 frame of 2-bit colours in a build buffer. After
//   FRAME_SLOTS words the build buffer is committed to the display buffer in
//   one edge, together with the frame's ball position and conflict status.
//   The display buffer is read through a registered random-access port.
//   A saturating error counter tracks reserved-colour words, and an idle
//   counter flags a link that has stopped sending.
//
// Colour coding: 00 blank, 01 ball, 10 bar, 11 reserved (counted, not drawn).
//
// Ports:
//   CLK   system clock
//   RSTn  synchronous active-low reset; clears both buffers, all counters,
//         latches and outputs, and discards any partial frame
//   bus   led_scan_frame_decoder_if.slave (see interface header)
//
// Parameters:
//   FRAME_SLOTS  scan slots per frame (7-bit slot counter)
//   TIMEOUT      idle cycles without SAMPLE before STALE (23-bit counter)
// ---------------------------------------------------------------------------
module led_scan_frame_decoder #(
    parameter int FRAME_SLOTS = 128,
    parameter int TIMEOUT     = 4000000
) (
    input logic                      CLK,
    input logic                      RSTn,
    led_scan_frame_decoder_if.slave  bus
);

    localparam int SLOT_W = 7;
    localparam int IDLE_W = 23;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        COL_BLANK = 2'b00,
        COL_BALL  = 2'b01,
        COL_BAR   = 2'b10,
        COL_RSVD  = 2'b11
    } colour_e;

    typedef logic [FRAME_SLOTS-1:0][1:0] frame_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    frame_t              build_q,        build_d;
    frame_t              display_q,      display_d;
    logic [SLOT_W-1:0]   slot_q,         slot_d;
    logic [IDLE_W-1:0]   idle_q,         idle_d;

    // Per-frame latches, accumulated while the frame is being built.
    logic                conflict_lat_q, conflict_lat_d;
    logic                ball_seen_q,    ball_seen_d;
    logic [2:0]          ball_x_lat_q,   ball_x_lat_d;
    logic [3:0]          ball_y_lat_q,   ball_y_lat_d;

    // Registered outputs.
    logic [1:0]          rd_data_q,      rd_data_d;
    logic                frame_done_q,   frame_done_d;
    logic                conflict_q,     conflict_d;
    logic                ball_valid_q,   ball_valid_d;
    logic [2:0]          ball_x_q,       ball_x_d;
    logic [3:0]          ball_y_q,       ball_y_d;
    logic [7:0]          err_cnt_q,      err_cnt_d;
    logic                stale_q,        stale_d;

    // ------------------------------------------------------------------
    // Word decode
    // ------------------------------------------------------------------
    colour_e             col;
    logic [6:0]          idx;
    logic [1:0]          cur;
    logic                unused_led_bit;

    assign col            = colour_e'(bus.LEDin[9:8]);
    assign idx            = bus.LEDin[6:0];
    assign unused_led_bit = bus.LEDin[7];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    always_comb begin
        build_d        = build_q;
        display_d      = display_q;
        slot_d         = slot_q;
        conflict_lat_d = conflict_lat_q;
        ball_seen_d    = ball_seen_q;
        ball_x_lat_d   = ball_x_lat_q;
        ball_y_lat_d   = ball_y_lat_q;
        conflict_d     = conflict_q;
        ball_valid_d   = ball_valid_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        err_cnt_d      = err_cnt_q;
        frame_done_d   = 1'b0;
        cur            = build_q[idx];

        // Read-before-write: the read always sees the current display, so on
        // a commit edge it returns the old frame.
        rd_data_d      = display_q[bus.RD_ADDR];

        if (bus.SAMPLE) begin
            // NOTE: blocking assignments here are deliberate; the commit below
            // must see the build buffer and latches with this word merged in.
            case (col)
                COL_BALL, COL_BAR: begin
                    if (cur == COL_BLANK) begin
                        build_d[idx] = col;
                    end else if (cur != col) begin
                        // Ball and bar on one pixel: bar wins, record clash.
                        build_d[idx]   = COL_BAR;
                        conflict_lat_d = 1'b1;
                    end
                    if (col == COL_BALL) begin
                        ball_seen_d  = 1'b1;
                        ball_x_lat_d = idx[2:0];
                        ball_y_lat_d = idx[6:3];
                    end
                end
                COL_RSVD: begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                COL_BLANK: ;
            endcase

            if (slot_q == LAST_SLOT) begin
                // Commit the merged frame and start a fresh one.
                display_d      = build_d;
                build_d        = '0;
                slot_d         = '0;
                conflict_d     = conflict_lat_d;
                ball_valid_d   = ball_seen_d;
                ball_x_d       = ball_seen_d ? ball_x_lat_d : 3'd0;
                ball_y_d       = ball_seen_d ? ball_y_lat_d : 4'd0;
                conflict_lat_d = 1'b0;
                ball_seen_d    = 1'b0;
                ball_x_lat_d   = 3'd0;
                ball_y_lat_d   = 4'd0;
                frame_done_d   = 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    // Idle counter saturates at TIMEOUT; STALE follows the counter reaching
    // it, so a SAMPLE cycle clears both on the same edge. The partial frame
    // is untouched by staleness.
    always_comb begin
        if (bus.SAMPLE) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 1'b1;
        end
        stale_d = (idle_d == IDLE_MAX);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: the frame buffers are flops, not RAM, because reset must blank
    // every pixel of both buffers in a single edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            build_q        <= '0;
            display_q      <= '0;
            slot_q         <= '0;
            idle_q         <= '0;
            conflict_lat_q <= 1'b0;
            ball_seen_q    <= 1'b0;
            ball_x_lat_q   <= 3'd0;
            ball_y_lat_q   <= 4'd0;
            rd_data_q      <= 2'b00;
            frame_done_q   <= 1'b0;
            conflict_q     <= 1'b0;
            ball_valid_q   <= 1'b0;
            ball_x_q       <= 3'd0;
            ball_y_q       <= 4'd0;
            err_cnt_q      <= 8'd0;
            stale_q        <= 1'b0;
        end else begin
            build_q        <= build_d;
            display_q      <= display_d;
            slot_q         <= slot_d;
            idle_q         <= idle_d;
            conflict_lat_q <= conflict_lat_d;
            ball_seen_q    <= ball_seen_d;
            ball_x_lat_q   <= ball_x_lat_d;
            ball_y_lat_q   <= ball_y_lat_d;
            rd_data_q      <= rd_data_d;
            frame_done_q   <= frame_done_d;
            conflict_q     <= conflict_d;
            ball_valid_q   <= ball_valid_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            err_cnt_q      <= err_cnt_d;
            stale_q        <= stale_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.RD_DATA    = rd_data_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.BALL_VALID = ball_valid_q;
    assign bus.BALL_X     = ball_x_q;
    assign bus.BALL_Y     = ball_y_q;
    assign bus.CONFLICT   = conflict_q;
    assign bus.ERR_CNT    = err_cnt_q;
    assign bus.STALE      = stale_q;

endmodule

// File: tb/tb_led_scan_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_led_scan_frame_decoder
//
// Directed stimulus for led_scan_frame_decoder. Every frame sent pushes its
// expected commit status onto a queue; a monitor pops one entry per
// FRAME_DONE pulse and compares. Pixel reads, ERR_CNT and STALE are checked
// inline against hand-computed values. Inputs are driven and outputs sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_led_scan_frame_decoder;

    localparam int SLOTS      = 128;
    localparam int TIMEOUT_TB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_scan_frame_decoder_if bus ();

    led_scan_frame_decoder #(
        .FRAME_SLOTS (SLOTS),
        .TIMEOUT     (TIMEOUT_TB)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       bv;
        logic [2:0] x;
        logic [3:0] y;
        logic       cf;
    } frame_exp_t;

    frame_exp_t exp_q[$];
    frame_exp_t mon_e;
    logic [9:0] fw[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One word per clock; called and returning on a falling edge.
    task automatic send(input logic [9:0] w);
        bus.SAMPLE = 1'b1;
        bus.LEDin  = w;
        @(negedge clk);
        bus.SAMPLE = 1'b0;
        bus.LEDin  = '0;
    endtask

    // Blank padding first, then the queued words, so the last queued word
    // occupies the final slot of the frame.
    task automatic send_frame(input frame_exp_t e);
        int pad;
        exp_q.push_back(e);
        pad = SLOTS - fw.size();
        for (int i = 0; i < pad; i++) send(10'h000);
        for (int i = 0; i < fw.size(); i++) send(fw[i]);
        fw.delete();
    endtask

    task automatic read_chk(input string name, input logic [6:0] addr,
                            input logic [1:0] exp);
        bus.RD_ADDR = addr;
        @(negedge clk);
        check(name, bus.RD_DATA, exp);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.FRAME_DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done: got unexpected pulse expected none (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ball_valid", bus.BALL_VALID, mon_e.bv);
                check("ball_x",     bus.BALL_X,     mon_e.x);
                check("ball_y",     bus.BALL_Y,     mon_e.y);
                check("conflict",   bus.CONFLICT,   mon_e.cf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.SAMPLE  = 1'b0;
        bus.LEDin   = '0;
        bus.RD_ADDR = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data",    bus.RD_DATA,    0);
        check("rst_frame_done", bus.FRAME_DONE, 0);
        check("rst_ball_valid", bus.BALL_VALID, 0);
        check("rst_conflict",   bus.CONFLICT,   0);
        check("rst_err_cnt",    bus.ERR_CNT,    0);
        check("rst_stale",      bus.STALE,      0);
        rst_n = 1'b1;
        @(negedge clk);

        // Blank frame: commit with nothing, all pixels blank.
        send_frame('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        for (int a = 0; a < SLOTS; a++) read_chk("blank_pix", 7'(a), 2'b00);
        check("blank_q_drained", exp_q.size(), 0);

        // Bars at 104..106, ball at 58 (y7,x2) in the last slot.
        // RD_ADDR held at 58 across the commit: old value on the commit edge.
        bus.RD_ADDR = 7'd58;
        fw = '{10'h268, 10'h269, 10'h26A, 10'h13A};
        send_frame('{bv: 1'b1, x: 3'd2, y: 4'd7, cf: 1'b0});
        check("rbw_old", bus.RD_DATA, 2'b00);
        @(negedge clk);
        check("rbw_new", bus.RD_DATA, 2'b01);
        read_chk("pix104", 7'd104, 2'b10);
        read_chk("pix105", 7'd105, 2'b10);
        read_chk("pix106", 7'd106, 2'b10);
        read_chk("pix107", 7'd107, 2'b00);
        read_chk("pix58",  7'd58,  2'b01);
        read_chk("pix0",   7'd0,   2'b00);

        // Ball then bar on 104; the clashing bar is the frame's last word.
        fw = '{10'h168, 10'h268};
        send_frame('{bv: 1'b1, x: 3'd0, y: 4'd13, cf: 1'b1});
        read_chk("clash_pix104", 7'd104, 2'b10);
        read_chk("clash_pix58",  7'd58,  2'b00);

        // Clean frame with two balls: the later one (idx 127) is reported.
        fw = '{10'h105, 10'h200, 10'h17F};
        send_frame('{bv: 1'b1, x: 3'd7, y: 4'd15, cf: 1'b0});
        read_chk("two_ball_pix5",   7'd5,   2'b01);
        read_chk("two_ball_pix0",   7'd0,   2'b10);
        read_chk("two_ball_pix127", 7'd127, 2'b01);
        read_chk("two_ball_pix104", 7'd104, 2'b00);
        repeat (5) @(negedge clk);
        check("hold_ball_x",     bus.BALL_X,     7);
        check("hold_ball_y",     bus.BALL_Y,     15);
        check("hold_ball_valid", bus.BALL_VALID, 1);
        check("hold_conflict",   bus.CONFLICT,   0);

        // Reserved-colour words: counted, never drawn.
        fw = '{10'h301, 10'h302, 10'h37F};
        send_frame('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        check("err_cnt_3", bus.ERR_CNT, 3);
        read_chk("rsvd_pix1",   7'd1,   2'b00);
        read_chk("rsvd_pix2",   7'd2,   2'b00);
        read_chk("rsvd_pix127", 7'd127, 2'b00);

        // 300 more: two full frames plus 44 slots of a partial one.
        exp_q.push_back('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        exp_q.push_back('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        for (int i = 0; i < 300; i++) send(10'h300);
        check("err_cnt_sat", bus.ERR_CNT, 255);

        // Stale after 16 idle edges; first SAMPLE clears it.
        repeat (TIMEOUT_TB - 1) @(negedge clk);
        check("stale_pre", bus.STALE, 0);
        @(negedge clk);
        check("stale_set", bus.STALE, 1);
        repeat (10) @(negedge clk);
        check("stale_hold", bus.STALE, 1);
        send(10'h000);
        check("stale_clr", bus.STALE, 0);

        // Partial frame survived: 45 slots so far, 83 more complete it.
        exp_q.push_back('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        for (int i = 0; i < 82; i++) send(10'h000);
        send(10'h250);
        @(negedge clk);
        check("stale_q_drained", exp_q.size(), 0);
        check("err_cnt_still",   bus.ERR_CNT, 255);
        read_chk("pix80", 7'd80, 2'b10);

        // Reset after 60 slots (with a ball) discards the partial frame.
        for (int i = 0; i < 59; i++) send(10'h000);
        send(10'h13A);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_rd_data",    bus.RD_DATA,    0);
        check("rst2_err_cnt",    bus.ERR_CNT,    0);
        check("rst2_ball_valid", bus.BALL_VALID, 0);
        check("rst2_frame_done", bus.FRAME_DONE, 0);
        rst_n = 1'b1;
        read_chk("rst2_pix80", 7'd80, 2'b00);

        fw = '{10'h268};
        send_frame('{bv: 1'b0, x: 3'd0, y: 4'd0, cf: 1'b0});
        read_chk("post_rst_pix104", 7'd104, 2'b10);
        read_chk("post_rst_pix58",  7'd58,  2'b00);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scan_frame_decoder.md
Name: led_scan_frame_decoder

Overview:
- Receiving end of the multiplexed 10-bit LED scan word stream that the game logic emits, one pixel per slot.
- Rebuilds a full 8x16 two-bit-colour frame from those time-multiplexed slot words into a double-buffered frame store.
- Exposes a registered random-access read port, per-frame ball position, conflict and error status, and a stale-link flag.
- Sits between the game core and a matrix driver or on-chip checker, so display rendering and game logic can be verified independently.

Parameters:
- FRAME_SLOTS, 128, number of scan slots per frame; slot counter width is 7 bits.
- TIMEOUT, 4000000, idle CLK cycles without SAMPLE before STALE asserts; counter width is 23 bits.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  reset, synchronous active-low.
- SAMPLE  in  1  single-cycle strobe; LEDin is valid in that cycle (same rate as the sender's slot advance).
- LEDin  in  10  scan word; [9:8] colour (00 blank, 01 ball, 10 bar, 11 reserved), [7] ignored, [6:0] pixel index = y*8+x.
- RD_ADDR  in  7  read pixel index.
- RD_DATA  out  2  colour of RD_ADDR in the display buffer; 1-cycle latency.
- FRAME_DONE  out  1  one-cycle pulse when a new frame is committed.
- BALL_VALID  out  1  committed frame contained at least one ball word.
- BALL_X  out  3  x of the last ball word in the committed frame.
- BALL_Y  out  4  y of the last ball word in the committed frame.
- CONFLICT  out  1  committed frame had two different non-blank colours on one pixel.
- ERR_CNT  out  8  saturating count of reserved-colour (11) words since reset.
- STALE  out  1  no SAMPLE seen for TIMEOUT cycles.

Behaviour:
- Reset is synchronous. Any rising CLK edge with RSTn=0 clears:
  - both buffers to 00 (blank);
  - slot counter, idle counter and all internal latches;
  - all outputs to 0, including RD_DATA.
- Reset mid-frame discards the partial frame. No FRAME_DONE is issued.
- Decode of each SAMPLE word, using col=LEDin[9:8] and idx=LEDin[6:0]:
  - col=00: nothing is written. The slot still counts.
  - col=01 or 10, build[idx]==00: build[idx] <= col.
  - col=01 or 10, build[idx]==col: no change.
  - col=01 or 10, build[idx] is a different non-blank colour: build[idx] <= 10 (bar wins), and the conflict latch is set.
  - col=01 also records ball_x=idx[2:0] and ball_y=idx[6:3] and sets the ball-seen latch. A later ball word overwrites the earlier one.
  - col=11: nothing is written. ERR_CNT increments and saturates at 255. The slot still counts.
- Slot counter:
  - Increments on each SAMPLE.
  - When SAMPLE arrives with slot counter == FRAME_SLOTS-1, that last word is merged first, then the frame commits.
- Frame commit, all on one edge:
  - display <= merged build frame;
  - build <= all blank;
  - slot counter <= 0;
  - CONFLICT <= conflict latch (including the last word); BALL_VALID, BALL_X, BALL_Y <= their latches (including the last word);
  - all latches clear.
  - FRAME_DONE is high for exactly the cycle following the commit edge.
- Between commits, CONFLICT, BALL_VALID, BALL_X and BALL_Y hold their values.
- If BALL_VALID=0 on a commit, BALL_X and BALL_Y are forced to 0.
- Read port:
  - RD_DATA <= display[RD_ADDR] on every edge.
  - On the commit edge the read returns the pre-commit display (read-before-write). The new frame is visible one cycle later.
- SAMPLE without reset never stalls. There is no back-pressure.
- STALE / idle counter:
  - The idle counter increments every cycle SAMPLE=0 and saturates at TIMEOUT.
  - STALE is registered and asserts on the edge where the counter reaches TIMEOUT.
  - A SAMPLE cycle clears the counter and STALE on that edge. The word is still decoded normally.
  - The partial frame is retained across a stale period.

Test Plan:
- Reset, then 128 blank SAMPLE words → FRAME_DONE one pulse, BALL_VALID=0, CONFLICT=0, every RD_ADDR reads 00.
- Frame with word 10'h268 (bar, idx 104), 10'h269, 10'h26A and ball word 10'h100+58 (y7,x2), remainder blank → after FRAME_DONE: RD_DATA at 104/105/106=10, at 58=01, BALL_X=2, BALL_Y=7, BALL_VALID=1.
- Ball 10'h168 then bar 10'h268 at the same idx 104 in one frame → pixel 104 reads 10 and CONFLICT=1. The next clean frame → CONFLICT=0.
- Three 10'h3xx words in a frame → ERR_CNT=3, no pixels written. Then 300 such words → ERR_CNT=255 (saturated).
- Hold RD_ADDR=58 across a commit that changes pixel 58 from 00 to 01 → RD_DATA is 00 on the commit edge and 01 one cycle later.
- TIMEOUT overridden to 16, then no SAMPLE for 16 cycles → STALE=1 at the 16th; next SAMPLE → STALE=0 that edge. Reset after 60 slots → no FRAME_DONE, then a full frame commits normally.
